// File: rtl/vid_timing_if.sv
// Raster timing bundle produced by vid_timing_gen.
//
// Handshake: pix_en is a one-clock "pixel valid" strobe with no ready; the
// consumer must accept every pixel. hcnt/vcnt and the decoded levels
// (hsync, hblank, vsync, vblank, de) are stable between strobes and always
// describe the pixel shown in the same cycle. line_start/frame_start are
// one-clock strobes coinciding with the pix_en of pixel (0,vcnt)/(0,0).
//
// Signals:
//   pix_en                    one-clock pulse per pixel
//   hcnt, vcnt [CW]           current pixel and line
//   hsync, hblank             horizontal decode
//   vsync, vblank             vertical decode
//   de                        !hblank && !vblank
//   line_start, frame_start   one-clock strobes
// Modports: master (timing generator), slave (pixel fetch / FIFO side).
interface vid_timing_if #(
  parameter int CW = 13
);
  logic          pix_en;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          hsync;
  logic          hblank;
  logic          vsync;
  logic          vblank;
  logic          de;
  logic          line_start;
  logic          frame_start;

  modport master (
    output pix_en, hcnt, vcnt, hsync, hblank, vsync, vblank, de,
           line_start, frame_start
  );

  modport slave (
    input pix_en, hcnt, vcnt, hsync, hblank, vsync, vblank, de,
          line_start, frame_start
  );
endinterface

// File: rtl/vid_timing_gen.sv
// Programmable raster timing generator.
//
// Divides clk into a pixel enable (period pcnt+1 clocks), runs horizontal and
// vertical counters against shadowed geometry and produces registered
// sync/blank/de levels plus line and frame strobes. Geometry is loaded into a
// shadow on cfg_load and moves into the active set only at a frame wrap (or
// when leaving IDLE), so a frame is never drawn with mixed geometry.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   en                      run request
//   pcnt [DIVW]             pixel divider
//   hsize, hsync_start, hsync_end, hend  horizontal geometry [CW]
//   vsize, vsync_start, vsync_end, vend  vertical geometry [CW]
//   cfg_load                sample geometry and pcnt into the shadow
//   vt (master)             timing outputs, see vid_timing_if
//   cfg_err                 sticky: last cfg_load was rejected
//   busy                    generator not idle
//   dbg_state [2]           current FSM state (IDLE=0, RUN=1, STOP=2)
//   irq_line [CW], irq      only with VID_TIMING_LINE_IRQ_EN defined: irq
//                           pulses with the line_start whose new vcnt
//                           equals irq_line
//
// Optional feature macro: VID_TIMING_LINE_IRQ_EN.
module vid_timing_gen #(
  parameter int CW   = 13,
  parameter int DIVW = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [DIVW-1:0] pcnt,
  input  logic [CW-1:0]   hsize,
  input  logic [CW-1:0]   hsync_start,
  input  logic [CW-1:0]   hsync_end,
  input  logic [CW-1:0]   hend,
  input  logic [CW-1:0]   vsize,
  input  logic [CW-1:0]   vsync_start,
  input  logic [CW-1:0]   vsync_end,
  input  logic [CW-1:0]   vend,
  input  logic            cfg_load,
`ifdef VID_TIMING_LINE_IRQ_EN
  input  logic [CW-1:0]   irq_line,
  output logic            irq,
`endif
  vid_timing_if.master    vt,
  output logic            cfg_err,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

  typedef struct packed {
    logic [DIVW-1:0] pcnt;
    logic [CW-1:0]   hsize;
    logic [CW-1:0]   hss;
    logic [CW-1:0]   hse;
    logic [CW-1:0]   hend;
    logic [CW-1:0]   vsize;
    logic [CW-1:0]   vss;
    logic [CW-1:0]   vse;
    logic [CW-1:0]   vend;
  } geom_t;

  state_t          state_q, state_d;
  geom_t           cfg_in, sh_q, ac_q, geom_d;
  logic            pend_q, cfg_ok_q, cfg_err_q;
  logic            prime_q;   // first RUN edge: emit pixel (0,0) at once
  logic [DIVW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic            cfg_valid, tick, h_wrap, f_wrap, take, run_d;
  logic            pix_d, ls_d, fs_d, hs_d, hb_d, vs_d, vb_d;

  assign cfg_in = '{pcnt: pcnt, hsize: hsize, hss: hsync_start,
                    hse: hsync_end, hend: hend, vsize: vsize,
                    vss: vsync_start, vse: vsync_end, vend: vend};

  assign cfg_valid = (hend != '0) && (hsize <= hend) &&
                     (hsync_start < hsync_end) && (hsync_end <= hend) &&
                     (vend != '0) && (vsize <= vend) &&
                     (vsync_start < vsync_end) && (vsync_end <= vend);

  always_comb begin
    tick    = prime_q || (dcnt_q == ac_q.pcnt);
    h_wrap  = !prime_q && tick && (hcnt_q == ac_q.hend);
    f_wrap  = h_wrap && (vcnt_q == ac_q.vend);
    state_d = state_q;
    case (state_q)
      IDLE:    if (en && cfg_ok_q) state_d = RUN;
      RUN:     if (!en) state_d = STOP;
      STOP:    if (en) state_d = RUN;
               else if (f_wrap) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Shadow is adopted when leaving IDLE or at a frame wrap.
    take   = pend_q && (((state_q == IDLE) && (state_d == RUN)) ||
                        ((state_q != IDLE) && f_wrap));
    geom_d = take ? sh_q : ac_q;

    run_d  = (state_q != IDLE) && (state_d != IDLE);
    dcnt_d = '0;
    hcnt_d = '0;
    vcnt_d = '0;
    if (run_d) begin
      dcnt_d = tick ? '0 : dcnt_q + DIVW'(1);
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (prime_q) begin
        hcnt_d = '0;
        vcnt_d = '0;
      end else if (tick) begin
        if (h_wrap) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == ac_q.vend) ? '0 : vcnt_q + CW'(1);
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
    end

    // Decode from next-state counters so levels line up with hcnt/vcnt.
    pix_d = run_d && tick;
    ls_d  = pix_d && (hcnt_d == '0);
    fs_d  = ls_d && (vcnt_d == '0);
    hb_d  = !run_d || (hcnt_d >= geom_d.hsize);
    vb_d  = !run_d || (vcnt_d >= geom_d.vsize);
    hs_d  = run_d && (hcnt_d >= geom_d.hss) && (hcnt_d < geom_d.hse);
    vs_d  = run_d && (vcnt_d >= geom_d.vss) && (vcnt_d < geom_d.vse);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      sh_q           <= '0;
      ac_q           <= '0;
      pend_q         <= 1'b0;
      cfg_ok_q       <= 1'b0;
      cfg_err_q      <= 1'b0;
      prime_q        <= 1'b0;
      dcnt_q         <= '0;
      hcnt_q         <= '0;
      vcnt_q         <= '0;
      vt.pix_en      <= 1'b0;
      vt.hsync       <= 1'b0;
      vt.hblank      <= 1'b1;
      vt.vsync       <= 1'b0;
      vt.vblank      <= 1'b1;
      vt.de          <= 1'b0;
      vt.line_start  <= 1'b0;
      vt.frame_start <= 1'b0;
    end else begin
      state_q <= state_d;
      prime_q <= (state_q == IDLE) && (state_d == RUN);
      ac_q    <= geom_d;
      if (cfg_load) begin
        cfg_err_q <= !cfg_valid;
        if (cfg_valid) begin
          sh_q     <= cfg_in;
          cfg_ok_q <= 1'b1;
        end
      end
      // A valid load on a wrap edge wins: its shadow waits for the next wrap.
      if (cfg_load && cfg_valid) pend_q <= 1'b1;
      else if (take)             pend_q <= 1'b0;
      dcnt_q         <= dcnt_d;
      hcnt_q         <= hcnt_d;
      vcnt_q         <= vcnt_d;
      vt.pix_en      <= pix_d;
      vt.hsync       <= hs_d;
      vt.hblank      <= hb_d;
      vt.vsync       <= vs_d;
      vt.vblank      <= vb_d;
      vt.de          <= !hb_d && !vb_d;
      vt.line_start  <= ls_d;
      vt.frame_start <= fs_d;
    end
  end

`ifdef VID_TIMING_LINE_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= ls_d && (vcnt_d == irq_line);
  end
`endif

  assign vt.hcnt   = hcnt_q;
  assign vt.vcnt   = vcnt_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: directed scenarios followed by randomized
// configuration / enable traffic. A reference model computes, every clock,
// the expected output vector from elapsed clocks within the current frame
// (pixel = clocks / period, hcnt/vcnt = pixel mod / div line length) and
// queues it; a monitor on the falling edge pops and compares.
module tb_vid_timing_gen;
  localparam int CW   = 13;
  localparam int DIVW = 6;
  localparam int W    = 37;

  typedef struct {
    int pcnt, hsize, hss, hse, hend, vsize, vss, vse, vend;
  } geo_t;

  // ---------------- clock / reset / stimulus signals ----------------
  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            en = 1'b0;
  logic            cfg_load = 1'b0;
  logic [DIVW-1:0] pcnt = '0;
  logic [CW-1:0]   hsize = '0, hsync_start = '0, hsync_end = '0, hend = '0;
  logic [CW-1:0]   vsize = '0, vsync_start = '0, vsync_end = '0, vend = '0;
  logic [CW-1:0]   irq_line = '0;
  logic            cfg_err, busy, irq;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  vid_timing_if #(.CW(CW)) vt ();

  vid_timing_gen #(.CW(CW), .DIVW(DIVW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .pcnt(pcnt),
    .hsize(hsize), .hsync_start(hsync_start), .hsync_end(hsync_end),
    .hend(hend), .vsize(vsize), .vsync_start(vsync_start),
    .vsync_end(vsync_end), .vend(vend), .cfg_load(cfg_load),
`ifdef VID_TIMING_LINE_IRQ_EN
    .irq_line(irq_line), .irq(irq),
`endif
    .vt(vt), .cfg_err(cfg_err), .busy(busy), .dbg_state(dbg_state)
  );

`ifndef VID_TIMING_LINE_IRQ_EN
  assign irq = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b1;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  geo_t m_sh, m_act;
  bit   m_pend = 0, m_ok = 0, m_err = 0, m_on = 0, m_first = 0, m_stopping = 0;
  int   m_c = 0, m_h = 0, m_v = 0;

  function automatic int frame_len(geo_t g);
    return (g.pcnt + 1) * (g.hend + 1) * (g.vend + 1);
  endfunction

  function automatic bit geo_ok(geo_t g);
    return g.hend >= 1 && g.hsize <= g.hend && g.hss < g.hse && g.hse <= g.hend &&
           g.vend >= 1 && g.vsize <= g.vend && g.vss < g.vse && g.vse <= g.vend;
  endfunction

  function automatic geo_t cur_inputs();
    geo_t g;
    g.pcnt = int'(pcnt);   g.hsize = int'(hsize); g.hss = int'(hsync_start);
    g.hse = int'(hsync_end); g.hend = int'(hend); g.vsize = int'(vsize);
    g.vss = int'(vsync_start); g.vse = int'(vsync_end); g.vend = int'(vend);
    return g;
  endfunction

  function automatic logic [W-1:0] pack(bit pix, int h, int v, bit hs, bit hb,
      bit vs, bit vb, bit de_b, bit ls, bit fs, bit ce, bit bz, bit iq);
    logic [CW-1:0] hh, vv;
    hh = CW'(h);
    vv = CW'(v);
    return {pix, hh, vv, hs, hb, vs, vb, de_b, ls, fs, ce, bz, iq};
  endfunction

  always @(posedge clk) begin
    int  p, n, h, v;
    bit  pix, hs, hb, vs, vb, ls, fs, iq;
    geo_t g;
    if (!reset_n) begin
      m_sh = '{default: 0}; m_act = '{default: 0};
      m_pend = 0; m_ok = 0; m_err = 0; m_on = 0; m_first = 0;
      m_stopping = 0; m_c = 0;
    end else begin
      if (!m_on) begin
        if (en && m_ok) begin
          m_on = 1; m_first = 1; m_stopping = 0;
          if (m_pend) begin m_act = m_sh; m_pend = 0; end
        end
      end else begin
        if (m_first) begin
          m_first = 0; m_c = 0;
        end else begin
          m_c++;
          if (m_c == frame_len(m_act)) begin
            m_c = 0;
            if (m_stopping && !en) m_on = 0;
            if (m_pend) begin m_act = m_sh; m_pend = 0; end
          end
        end
        m_stopping = !en;
      end
      if (cfg_load) begin
        g = cur_inputs();
        if (geo_ok(g)) begin m_sh = g; m_pend = 1; m_err = 0; m_ok = 1; end
        else m_err = 1;
      end
    end
    if (m_on && !m_first) begin
      p   = m_act.pcnt + 1;
      n   = m_c / p;
      h   = n % (m_act.hend + 1);
      v   = n / (m_act.hend + 1);
      pix = (m_c % p) == 0;
      hb  = h >= m_act.hsize;
      vb  = v >= m_act.vsize;
      hs  = h >= m_act.hss && h < m_act.hse;
      vs  = v >= m_act.vss && v < m_act.vse;
      ls  = pix && h == 0;
      fs  = ls && v == 0;
    end else begin
      h = 0; v = 0; pix = 0; hb = 1; vb = 1; hs = 0; vs = 0; ls = 0; fs = 0;
    end
`ifdef VID_TIMING_LINE_IRQ_EN
    iq = ls && v == int'(irq_line);
`else
    iq = 0;
`endif
    m_h = h;
    m_v = v;
    exp_q.push_back(pack(pix, h, v, hs, hb, vs, vb, !hb && !vb, ls, fs,
                         m_err, m_on, iq));
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v, act_v;
    if (mon_on) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        exp_v = exp_q.pop_front();
        act_v = {vt.pix_en, vt.hcnt, vt.vcnt, vt.hsync, vt.hblank, vt.vsync,
                 vt.vblank, vt.de, vt.line_start, vt.frame_start, cfg_err,
                 busy, irq};
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL outputs t=%0t got %h need %h (hcnt %0d/%0d vcnt %0d/%0d)",
                   $time, act_v, exp_v, vt.hcnt, exp_v[35:23], vt.vcnt, exp_v[22:10]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int need);
    checks++;
    if (act != need) begin
      errors++;
      $display("FAIL %s got %0d need %0d", name, act, need);
    end
  endtask

  task automatic load_cfg(input int pc, input int hsz, input int hss, input int hse,
                          input int he, input int vsz, input int vss, input int vse,
                          input int ve);
    @(negedge clk);
    pcnt = DIVW'(pc); hsize = CW'(hsz); hsync_start = CW'(hss); hsync_end = CW'(hse);
    hend = CW'(he); vsize = CW'(vsz); vsync_start = CW'(vss); vsync_end = CW'(vse);
    vend = CW'(ve);
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // Interval in clocks between two consecutive line or frame strobes.
  task automatic measure(input bit frame, input string name, input int need);
    int n;
    n = 0;
    while (!(frame ? vt.frame_start : vt.line_start) && n < 3000) begin
      @(negedge clk); n++;
    end
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(frame ? vt.frame_start : vt.line_start) && n < 3000);
    chk(name, n, need);
  endtask

  task automatic wait_pos(input int h, input int v, input string name);
    int n;
    n = 0;
    while (!(m_on && !m_first && m_h == h && m_v == v) && n < 5000) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for hcnt %0d vcnt %0d", name, h, v);
    end
  endtask

  task automatic wait_hend(input int he, input string name);
    int n;
    n = 0;
    while (!(m_on && m_act.hend == he) && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for hend %0d", name, he);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hcnt"}, int'(vt.hcnt), 0);
    chk({tag, "_vcnt"}, int'(vt.vcnt), 0);
    chk({tag, "_hblank"}, int'(vt.hblank), 1);
    chk({tag, "_vblank"}, int'(vt.vblank), 1);
    chk({tag, "_pix_en"}, int'(vt.pix_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // Enable without any configuration: must stay idle.
    en = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_no_cfg_busy", int'(busy), 0);

    // Reference geometry: 5-clock pixels, 15 pixels x 10 lines.
    load_cfg(4, 8, 10, 12, 14, 6, 7, 8, 9);
    chk("load_ok_cfg_err", int'(cfg_err), 0);
    measure(0, "line_period_a", 75);
    measure(1, "frame_period_a", 750);

    // Rejected load leaves timing alone; next valid load (hsize 4) clears it.
    load_cfg(4, 8, 12, 10, 14, 6, 7, 8, 9);
    chk("bad_hsync_cfg_err", int'(cfg_err), 1);
    repeat (200) @(negedge clk);
    load_cfg(4, 4, 10, 12, 14, 6, 7, 8, 9);
    chk("reload_cfg_err", int'(cfg_err), 0);
    repeat (1600) @(negedge clk);

    // Graceful stop, resumed mid-frame, then a real stop to IDLE.
    wait_pos(0, 3, "stop_at_v3");
    en = 1'b0;
    wait_pos(0, 5, "resume_at_v5");
    en = 1'b1;
    repeat (100) @(negedge clk);
    en = 1'b0;
    n = 0;
    while (m_on && n < 3000) begin @(negedge clk); n++; end
    chk("stopped_busy", int'(busy), 0);
    chk("stopped_hblank", int'(vt.hblank), 1);
    chk("stopped_vblank", int'(vt.vblank), 1);
    en = 1'b1;

    // Minimum geometry at full pixel rate.
    load_cfg(0, 1, 0, 1, 1, 1, 0, 1, 1);
    wait_hend(1, "min_geom_applied");
    measure(0, "line_period_min", 2);
    measure(1, "frame_period_min", 4);
    load_cfg(0, 1, 0, 1, 1, 0, 0, 0, 0);
    chk("vend0_cfg_err", int'(cfg_err), 1);
    repeat (20) @(negedge clk);

    // Reset mid-frame clears everything, including cfg_ok.
    load_cfg(4, 8, 10, 12, 14, 6, 7, 8, 9);
    wait_hend(14, "geom_a_applied");
    wait_pos(6, 2, "reset_point");
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_idle_busy", int'(busy), 0);

    // Randomized traffic.
    irq_line = CW'(3);
    load_cfg(1, 3, 1, 2, 5, 2, 1, 2, 4);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin : valid_load
          int he, hse, ve, vse;
          he = $urandom_range(1, 10); hse = $urandom_range(1, he);
          ve = $urandom_range(1, 6);  vse = $urandom_range(1, ve);
          load_cfg($urandom_range(0, 3), $urandom_range(0, he), $urandom_range(0, hse - 1),
                   hse, he, $urandom_range(0, ve), $urandom_range(0, vse - 1), vse, ve);
        end
        1: load_cfg($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 12),
                    $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 8),
                    $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8));
        2: begin @(negedge clk); en = ~en; end
        default: begin @(negedge clk); irq_line = CW'($urandom_range(0, 6)); end
      endcase
      repeat ($urandom_range(1, 150)) @(negedge clk);
    end

    en = 1'b0;
    repeat (20) @(negedge clk);
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
